// File: rtl/npu_axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read master (AR/R) among N_REQ requesters, one burst in flight.
// Optional macro NPU_RD_ARB_PRIO0_EN gives requester 0 strict priority over the round-robin group.
module npu_axi_rd_arbiter #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 256,
    parameter int ID_W   = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        s_arvalid,
    output logic [N_REQ-1:0]        s_arready,
    input  logic [N_REQ*ADDR_W-1:0] s_araddr,
    input  logic [N_REQ*8-1:0]      s_arlen,
    input  logic [N_REQ*3-1:0]      s_arsize,
    output logic [N_REQ-1:0]        s_rvalid,
    input  logic [N_REQ-1:0]        s_rready,
    output logic [DATA_W-1:0]       s_rdata,
    output logic                    s_rlast,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    output logic [ADDR_W-1:0]       m_araddr,
    output logic [7:0]              m_arlen,
    output logic [2:0]              m_arsize,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    input  logic [DATA_W-1:0]       m_rdata,
    input  logic                    m_rlast,
    output logic                    busy,
    output logic [ID_W-1:0]         grant_id,
    output logic                    err_len
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0]        r_state;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_grant_id;
    logic [8:0]        r_beat_cnt;
    logic              r_err_len;
    logic              r_arvalid;
    logic [ADDR_W-1:0] r_araddr;
    logic [7:0]        r_arlen;
    logic [2:0]        r_arsize;

    logic [N_REQ-1:0]  w_cand;
    logic              w_prio0;
    logic              w_any;
    logic              w_hi_any;
    logic [ID_W-1:0]   w_lo_idx;
    logic [ID_W-1:0]   w_hi_idx;
    logic [ID_W-1:0]   w_winner;
    logic [ID_W-1:0]   w_next_ptr;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [7:0]        w_sel_len;
    logic [2:0]        w_sel_size;
    logic              w_sel_rready;
    logic              w_beat;

    // Winner search: lowest candidate at or above rr_ptr, else lowest candidate overall (wrap).
    always_comb begin
`ifdef NPU_RD_ARB_PRIO0_EN
        w_prio0 = s_arvalid[0];
        w_cand  = s_arvalid & ~N_REQ'(1'b1);
`else
        w_prio0 = 1'b0;
        w_cand  = s_arvalid;
`endif
        w_any    = 1'b0;
        w_hi_any = 1'b0;
        w_lo_idx = {ID_W{1'b0}};
        w_hi_idx = {ID_W{1'b0}};
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_any    = w_any | w_cand[i];
            w_lo_idx = w_cand[i] ? ID_W'(i) : w_lo_idx;
            w_hi_any = w_hi_any | (w_cand[i] && (ID_W'(i) >= r_rr_ptr));
            w_hi_idx = (w_cand[i] && (ID_W'(i) >= r_rr_ptr)) ? ID_W'(i) : w_hi_idx;
        end
        w_winner   = w_prio0 ? {ID_W{1'b0}} : (w_hi_any ? w_hi_idx : w_lo_idx);
        w_any      = w_any | w_prio0;
        w_next_ptr = (w_winner == ID_W'(N_REQ - 1)) ? {ID_W{1'b0}} : (w_winner + ID_W'(1'b1));
    end

    // Request-field mux and per-requester handshake routing.
    always_comb begin
        w_sel_addr   = {ADDR_W{1'b0}};
        w_sel_len    = 8'd0;
        w_sel_size   = 3'd0;
        w_sel_rready = 1'b0;
        s_arready    = {N_REQ{1'b0}};
        s_rvalid     = {N_REQ{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            w_sel_addr   = (w_winner == ID_W'(i)) ? s_araddr[i*ADDR_W +: ADDR_W] : w_sel_addr;
            w_sel_len    = (w_winner == ID_W'(i)) ? s_arlen[i*8 +: 8] : w_sel_len;
            w_sel_size   = (w_winner == ID_W'(i)) ? s_arsize[i*3 +: 3] : w_sel_size;
            w_sel_rready = w_sel_rready | (s_rready[i] && (r_grant_id == ID_W'(i)));
            s_arready[i] = (r_state == ST_IDLE) && w_any && (w_winner == ID_W'(i));
            s_rvalid[i]  = (r_state == ST_DATA) && m_rvalid && (r_grant_id == ID_W'(i));
        end
    end

    assign m_rready = (r_state == ST_DATA) && w_sel_rready;
    assign w_beat   = m_rvalid && m_rready;

    // Arbitration FSM, AR register stage and burst-length checker.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= {ID_W{1'b0}};
            r_grant_id <= {ID_W{1'b0}};
            r_beat_cnt <= 9'd0;
            r_err_len  <= 1'b0;
            r_arvalid  <= 1'b0;
            r_araddr   <= {ADDR_W{1'b0}};
            r_arlen    <= 8'd0;
            r_arsize   <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_araddr   <= w_sel_addr;
                        r_arlen    <= w_sel_len;
                        r_arsize   <= w_sel_size;
                        r_grant_id <= w_winner;
                        r_beat_cnt <= 9'd0;
                        r_arvalid  <= 1'b1;
                        r_state    <= ST_ADDR;
                        // A strict-priority grant to requester 0 leaves the rotation untouched.
                        if (!w_prio0) begin
                            r_rr_ptr <= w_next_ptr;
                        end
                    end
                end
                ST_ADDR: begin
                    if (r_arvalid && m_arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_beat) begin
                        r_beat_cnt <= (r_beat_cnt == 9'h1FF) ? r_beat_cnt : (r_beat_cnt + 9'd1);
                        if (m_rlast) begin
                            if (r_beat_cnt != {1'b0, r_arlen}) begin
                                r_err_len <= 1'b1;
                            end
                            r_state <= ST_IDLE;
                        end else if (r_beat_cnt == {1'b0, r_arlen}) begin
                            r_err_len <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_arvalid <= 1'b0;
                end
            endcase
        end
    end

    assign m_arvalid = r_arvalid;
    assign m_araddr  = r_araddr;
    assign m_arlen   = r_arlen;
    assign m_arsize  = r_arsize;
    assign s_rdata   = m_rdata;
    assign s_rlast   = m_rlast;
    assign busy      = (r_state != ST_IDLE);
    assign grant_id  = r_grant_id;
    assign err_len   = r_err_len;
endmodule

// File: tb/tb_npu_axi_rd_arbiter.sv
// Self-checking bench for npu_axi_rd_arbiter: randomized bursts checked against a behavioural
// round-robin / burst-length model; honours NPU_RD_ARB_PRIO0_EN when defined.
module tb_npu_axi_rd_arbiter;
    localparam int N  = 3;
    localparam int AW = 64;
    localparam int DW = 256;
    localparam int IW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
    logic [N*AW-1:0] s_araddr;
    logic [N*8-1:0]  s_arlen;
    logic [N*3-1:0]  s_arsize;
    logic [DW-1:0]   s_rdata, m_rdata;
    logic            s_rlast, m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
    logic [AW-1:0]   m_araddr;
    logic [7:0]      m_arlen;
    logic [2:0]      m_arsize;
    logic            busy, err_len;
    logic [IW-1:0]   grant_id;

    npu_axi_rd_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_rdata(s_rdata), .s_rlast(s_rlast),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_rdata(m_rdata), .m_rlast(m_rlast),
        .busy(busy), .grant_id(grant_id), .err_len(err_len)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int mdl_ptr = 0;
    bit mdl_err = 1'b0;
    logic [AW-1:0] req_addr [N];
    logic [7:0]    req_len  [N];
    logic [2:0]    req_size [N];

    // Reference arbitration: first requester at or above the pointer, otherwise the first overall.
    function automatic int mdl_pick(input logic [N-1:0] m);
        logic [N-1:0] rr;
        rr = m;
`ifdef NPU_RD_ARB_PRIO0_EN
        if (m[0]) return 0;
        rr[0] = 1'b0;
`endif
        for (int i = mdl_ptr; i < N; i++) if (rr[i]) return i;
        for (int i = 0; i < N; i++) if (rr[i]) return i;
        return -1;
    endfunction

    function automatic void mdl_grant(input int w);
`ifdef NPU_RD_ARB_PRIO0_EN
        if (w == 0) return;
`endif
        mdl_ptr = (w + 1) % N;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [7:0] l, input logic [2:0] s);
        req_addr[i] = a;
        req_len[i]  = l;
        req_size[i] = s;
        s_araddr[i*AW +: AW] = a;
        s_arlen[i*8 +: 8]    = l;
        s_arsize[i*3 +: 3]   = s;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n   = 1'b1;
        mdl_ptr = 0;
        mdl_err = 1'b0;
    endtask

    // One burst: request, optional AR backpressure with stray R data, then nbeats from the slave.
    task automatic do_burst(input logic [N-1:0] mask, input int nbeats, input int ar_delay,
                            input bit toggle_rr, input bit gaps, output int delivered);
        int w;
        int b;
        int guard;
        logic [N-1:0] oh;
        logic [N-1:0] exp_rv;
        delivered = 0;
        s_arvalid = mask;
        #1;
        w = mdl_pick(mask);
        oh = '0;
        oh[w] = 1'b1;
        n_chk++; if (s_arready !== oh) $display("FAIL arready: got %b expected %b", s_arready, oh); else n_pass++;
        tick();
        mdl_grant(w);
        s_arvalid = '0;
        #1;
        n_chk++; if (m_arvalid !== 1'b1) $display("FAIL arvalid_rise: got %b expected 1", m_arvalid); else n_pass++;
        n_chk++; if (grant_id !== IW'(w)) $display("FAIL grant_id: got %0d expected %0d", grant_id, w); else n_pass++;
        n_chk++; if (m_araddr !== req_addr[w]) $display("FAIL araddr: got %h expected %h", m_araddr, req_addr[w]); else n_pass++;
        n_chk++; if ({m_arlen, m_arsize} !== {req_len[w], req_size[w]}) $display("FAIL arlen_size: got %h/%0d expected %h/%0d", m_arlen, m_arsize, req_len[w], req_size[w]); else n_pass++;
        n_chk++; if (busy !== 1'b1) $display("FAIL busy_addr: got %b expected 1", busy); else n_pass++;
        for (int k = 0; k < ar_delay; k++) begin
            m_arready = 1'b0;
            m_rvalid  = 1'b1;
            m_rdata   = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            #1;
            n_chk++; if ({m_rready, s_rvalid} !== '0) $display("FAIL stray_addr: got rready=%b rvalid=%b expected 0", m_rready, s_rvalid); else n_pass++;
            tick();
            n_chk++; if ({m_arvalid, m_araddr, m_arlen} !== {1'b1, req_addr[w], req_len[w]}) $display("FAIL ar_stable: got %b %h %h expected 1 %h %h", m_arvalid, m_araddr, m_arlen, req_addr[w], req_len[w]); else n_pass++;
        end
        m_rvalid  = 1'b0;
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        #1;
        n_chk++; if (m_arvalid !== 1'b0) $display("FAIL arvalid_drop: got %b expected 0", m_arvalid); else n_pass++;
        b = 0;
        guard = 0;
        while (b < nbeats && guard < 100) begin
            m_rvalid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            m_rlast  = (b == nbeats - 1);
            for (int j = 0; j < DW / 32; j++) m_rdata[j*32 +: 32] = $urandom();
            s_rready = N'($urandom());
            s_rready[w] = toggle_rr ? (guard % 2 == 0) : ($urandom_range(0, 3) != 0);
            #1;
            exp_rv = m_rvalid ? oh : '0;
            n_chk++; if (s_rvalid !== exp_rv) $display("FAIL rvalid_route: got %b expected %b", s_rvalid, exp_rv); else n_pass++;
            n_chk++; if (m_rready !== s_rready[w]) $display("FAIL rready_mirror: got %b expected %b", m_rready, s_rready[w]); else n_pass++;
            if (s_rvalid[w] && s_rready[w]) begin
                delivered++;
                n_chk++; if ({s_rdata, s_rlast} !== {m_rdata, m_rlast}) $display("FAIL rdata: got %h/%b expected %h/%b", s_rdata, s_rlast, m_rdata, m_rlast); else n_pass++;
            end
            if (m_rvalid && m_rready) b++;
            tick();
            guard++;
        end
        if (guard >= 100) begin
            n_chk++;
            $display("FAIL beat_timeout: got %0d beats expected %0d", b, nbeats);
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        s_rready = '0;
        if (nbeats != int'(req_len[w]) + 1) mdl_err = 1'b1;
        #1;
        n_chk++; if (busy !== 1'b0) $display("FAIL busy_end: got %b expected 0", busy); else n_pass++;
        n_chk++; if (err_len !== mdl_err) $display("FAIL err_len: got %b expected %b", err_len, mdl_err); else n_pass++;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_chk++; if ({m_arvalid, m_araddr, m_arlen, m_arsize} !== '0) $display("FAIL reset_ar: got %b %h %h %h expected 0", m_arvalid, m_araddr, m_arlen, m_arsize); else n_pass++;
        n_chk++; if ({busy, grant_id, err_len, m_rready} !== '0) $display("FAIL reset_status: got busy=%b gid=%0d err=%b rready=%b expected 0", busy, grant_id, err_len, m_rready); else n_pass++;
        n_chk++; if ({s_arready, s_rvalid} !== '0) $display("FAIL reset_s: got %b %b expected 0", s_arready, s_rvalid); else n_pass++;
    endtask

    task automatic test_single();
        int d;
        set_req(1, 64'h1000, 8'd3, 3'd5);
        do_burst(3'b010, 4, 0, 1'b0, 1'b0, d);
        n_chk++; if (d !== 4) $display("FAIL single_beats: got %0d expected 4", d); else n_pass++;
        n_chk++; if (grant_id !== 3'd1) $display("FAIL single_gid: got %0d expected 1", grant_id); else n_pass++;
    endtask

    task automatic test_fairness();
        int d;
        int exp_id;
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, {32'($urandom()), 32'($urandom())}, 8'd0, 3'd5);
        for (int k = 0; k < 6; k++) begin
            do_burst(3'b111, 1, 0, 1'b0, 1'b0, d);
`ifdef NPU_RD_ARB_PRIO0_EN
            exp_id = 0;
`else
            exp_id = k % 3;
`endif
            n_chk++; if (grant_id !== IW'(exp_id)) $display("FAIL fair_order[%0d]: got %0d expected %0d", k, grant_id, exp_id); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int d;
        set_req(2, 64'hDEAD_BEEF_0000_2000, 8'd7, 3'd5);
        do_burst(3'b100, 8, 5, 1'b1, 1'b0, d);
        n_chk++; if (d !== 8) $display("FAIL bp_beats: got %0d expected 8", d); else n_pass++;
    endtask

    task automatic test_stray();
        s_arvalid = '0;
        m_rvalid  = 1'b1;
        m_rlast   = 1'b1;
        s_rready  = '1;
        #1;
        n_chk++; if ({m_rready, s_rvalid} !== '0) $display("FAIL stray_idle: got rready=%b rvalid=%b expected 0", m_rready, s_rvalid); else n_pass++;
        tick();
        n_chk++; if (busy !== 1'b0) $display("FAIL stray_busy: got %b expected 0", busy); else n_pass++;
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        s_rready = '0;
    endtask

    task automatic test_len_error();
        int d;
        set_req(0, 64'h4000, 8'd3, 3'd5);
        do_burst(3'b001, 2, 0, 1'b0, 1'b0, d);
        set_req(1, 64'h5000, 8'd1, 3'd5);
        do_burst(3'b010, 2, 1, 1'b0, 1'b1, d);
        n_chk++; if (grant_id !== 3'd1) $display("FAIL after_err_gid: got %0d expected 1", grant_id); else n_pass++;
    endtask

    task automatic test_random();
        int d;
        int w;
        int r;
        int nb;
        logic [N-1:0] mask;
        for (int it = 0; it < 25; it++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++)
                set_req(i, {32'($urandom()), 32'($urandom())}, 8'($urandom_range(0, 3)), 3'($urandom()));
            w  = mdl_pick(mask);
            r  = $urandom_range(0, 9);
            nb = int'(req_len[w]) + 1;
            if (r == 0 && req_len[w] != 8'd0) nb = int'(req_len[w]);
            if (r == 1) nb = int'(req_len[w]) + 2;
            do_burst(mask, nb, $urandom_range(0, 2), 1'b0, 1'b1, d);
            n_chk++; if (d !== nb) $display("FAIL rand_beats[%0d]: got %0d expected %0d", it, d, nb); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_burst();
        int d;
        set_req(1, 64'h6000, 8'd3, 3'd5);
        s_arvalid = 3'b010;
        tick();
        s_arvalid = '0;
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        m_rvalid  = 1'b1;
        m_rlast   = 1'b0;
        s_rready  = '1;
        tick();
        tick();
        m_rvalid = 1'b0;
        s_rready = '0;
        rst_n    = 1'b0;
        tick();
        n_chk++; if ({busy, m_arvalid, grant_id, err_len} !== '0) $display("FAIL midrst: got busy=%b arv=%b gid=%0d err=%b expected 0", busy, m_arvalid, grant_id, err_len); else n_pass++;
        rst_n   = 1'b1;
        mdl_ptr = 0;
        mdl_err = 1'b0;
        set_req(2, 64'h7000, 8'd1, 3'd5);
        do_burst(3'b100, 2, 0, 1'b0, 1'b0, d);
    endtask

    initial begin
        rst_n = 1'b0; s_arvalid = '0; s_rready = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rlast = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_stray();
        test_len_error();
        test_random();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/npu_axi_rd_arbiter.md
Name: npu_axi_rd_arbiter

Overview:
- Shares the single NPU AXI read master (AR/R channels of m_axi_*) among N internal read requesters: CQ descriptor fetch, DMA shim read side, GEMM operand fetch.
- Sits inside npu_top between the requesters and the m_axi read port.
- Round-robin arbitration, one outstanding burst at a time; R beats are routed to the granted requester until rlast.
- Also checks that the burst length matches arlen and flags a sticky error.

Parameters:
- N_REQ, 3, number of read requesters (2..8)
- ADDR_W, 64, AXI address width
- DATA_W, 256, AXI read data width
- ID_W, 3, width of grant_id; must satisfy 2**ID_W >= N_REQ

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- s_arvalid  in  N_REQ  per-requester read-address valid
- s_arready  out  N_REQ  per-requester read-address accept
- s_araddr  in  N_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- s_arlen  in  N_REQ*8  packed burst lengths (beats-1)
- s_arsize  in  N_REQ*3  packed beat sizes
- s_rvalid  out  N_REQ  per-requester read-data valid
- s_rready  in  N_REQ  per-requester read-data ready
- s_rdata  out  DATA_W  read data, broadcast to all requesters
- s_rlast  out  1  last beat, broadcast
- m_arvalid  out  1  AXI AR valid
- m_arready  in  1  AXI AR ready
- m_araddr  out  ADDR_W  AXI AR address
- m_arlen  out  8  AXI AR length
- m_arsize  out  3  AXI AR size
- m_rvalid  in  1  AXI R valid
- m_rready  out  1  AXI R ready
- m_rdata  in  DATA_W  AXI R data
- m_rlast  in  1  AXI R last
- busy  out  1  high in any state other than IDLE
- grant_id  out  ID_W  index of the current or last owner
- err_len  out  1  sticky burst-length mismatch flag

Behaviour:
- Reset is synchronous and active-low; clock is clk. rst_n is sampled on posedge clk.
- Reset values:
  - state=IDLE, m_arvalid=0, m_araddr=0, m_arlen=0, m_arsize=0
  - rr_ptr=0, grant_id=0, beat_cnt=0, err_len=0
  - all s_arready=0, all s_rvalid=0, m_rready=0, busy=0
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - Winner is the first i with s_arvalid[i]=1, searching from rr_ptr upward with wrap modulo N_REQ.
  - s_arready[winner]=1 combinationally in the same cycle; all other s_arready are 0.
  - On that clock edge: latch addr/len/size into the m_ar* registers; grant_id<=winner; rr_ptr<=(winner+1) mod N_REQ; beat_cnt<=0; m_arvalid<=1; go to ADDR.
  - Grant latency: m_arvalid is high 1 cycle after the request is accepted.
- ADDR:
  - Hold m_arvalid and all m_ar* fields stable until m_arvalid&&m_arready.
  - On that handshake: m_arvalid<=0; go to DATA.
  - s_arready is 0 for all requesters.
- DATA:
  - s_rvalid[grant_id]=m_rvalid; all other s_rvalid=0.
  - m_rready=s_rready[grant_id]; s_rdata=m_rdata; s_rlast=m_rlast.
  - Each beat (m_rvalid&&m_rready) increments beat_cnt (9-bit).
  - On a beat with m_rlast=1:
    - if beat_cnt != m_arlen, set err_len<=1
    - go to IDLE; the next grant can occur in the following cycle.
  - On a beat with m_rlast=0 and beat_cnt==m_arlen: set err_len<=1; stay in DATA until rlast.
- Outside DATA: m_rready=0; any stray m_rvalid is ignored and never forwarded.
- Arbitration boundaries:
  - A requester that deasserts s_arvalid before its grant is dropped from arbitration.
  - Simultaneous requests are resolved purely by rr_ptr.
  - With one continuous requester, it is regranted after each burst.
  - A single-beat burst (arlen=0) with rlast is legal: IDLE→ADDR→DATA→IDLE, minimum 3 cycles per burst.
- err_len clears only on reset.
- Reset mid-burst returns to IDLE immediately and drops m_arvalid. The downstream AXI slave shares rst_n and is reset together.

Optional Feature:
- Macro: NPU_RD_ARB_PRIO0_EN.
- When defined: requester 0 has strict priority — it wins in IDLE whenever s_arvalid[0]=1. rr_ptr is not updated on a requester-0 grant. Requesters 1..N_REQ-1 round-robin among themselves when requester 0 is idle.
- When undefined: all requesters, including 0, are pure round-robin as above.

Test Plan:
- Single request: s_arvalid[1]=1, addr=0x1000, arlen=3; slave returns 4 beats with rlast on beat 4. Required: m_araddr=0x1000 one cycle after s_arready[1]; only s_rvalid[1] pulses 4 times; grant_id=1; err_len=0; busy low after the last beat.
- Fairness: all 3 requesters hold s_arvalid continuously, arlen=0. Required: grant order 0,1,2,0,1,2 over 6 bursts. With NPU_RD_ARB_PRIO0_EN defined, the order is 0,0,0,...
- Backpressure: m_arready held low 5 cycles, then high; s_rready[2] toggles every cycle during 8 beats. Required: m_ar* fields stable while held; m_rready mirrors s_rready[2]; all 8 beats are delivered with no loss.
- Length error: arlen=3, slave asserts rlast on beat 2. Required: err_len=1 from the next cycle; FSM returns to IDLE; the next request is still granted.
- Stray data: m_rvalid=1 while in IDLE. Required: m_rready=0; all s_rvalid=0.
- Reset mid-burst: rst_n=0 during DATA after 2 of 4 beats. Required: next cycle state IDLE, m_arvalid=0, busy=0, grant_id=0, err_len=0.
